// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_ctrl
//  Purpose  : Stopwatch control FSM. Synchronises, debounces and edge-detects
//             the start/stop and clear/lap buttons, sequences the seconds
//             counter mode (clear/count/hold), handles lap freeze, counter
//             wrap detection and the display mux.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DB_CYCLES = 20,
  parameter int CNT_W     = 19,
  parameter int WRAP_VAL  = 500000
) (
  input  logic             clk,
  input  logic             hard_reset,
  input  logic             btn_start,
  input  logic             btn_clear,
  input  logic [CNT_W-1:0] sec_count,
  output logic [1:0]       en,
  output logic [1:0]       state,
  output logic             lap_valid,
  output logic [CNT_W-1:0] lap_value,
  output logic [CNT_W-1:0] disp_value,
  output logic             ovf
);

  // Debounce counter only needs to reach DB_CYCLES-1.
  localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0]   C_DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WRAP    = CNT_W'(WRAP_VAL);

  // Counter mode codes.
  localparam logic [1:0] C_EN_CLEAR = 2'b00;
  localparam logic [1:0] C_EN_COUNT = 2'b01;
  localparam logic [1:0] C_EN_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_WRAP  = 2'd3
  } state_t;

  // Raw buttons packed so both share one debounce implementation:
  // bit 0 = start/stop, bit 1 = clear/lap.
  logic [1:0] w_raw;
  logic [1:0] w_pulse;

  assign w_raw = {btn_clear, btn_start};

  // --------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic           r_sync1;
    logic           r_sync2;
    logic           r_db;
    logic           r_db_d;
    logic [DBW-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge hard_reset) begin
      if (!hard_reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
      end
    end

    // Debounced level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge hard_reset) begin
      if (!hard_reset) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_DB_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or negedge hard_reset) begin
      if (!hard_reset) begin
        r_db_d <= 1'b0;
      end else begin
        r_db_d <= r_db;
      end
    end

    // One-cycle pulse on a debounced press; releases are ignored.
    assign w_pulse[gi] = r_db & ~r_db_d;
  end

  logic w_start_p;
  logic w_clear_p;
  logic w_at_wrap;

  assign w_start_p = w_pulse[0];
  assign w_clear_p = w_pulse[1];
  assign w_at_wrap = (sec_count == C_WRAP);

  // --------------------------------------------------------------------------
  // Control FSM with registered mode code, lap register and overflow flag
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [1:0]       r_en;
  logic             r_lap_valid;
  logic [CNT_W-1:0] r_lap_value;
  logic             r_ovf;

  // State, counter mode and lap/overflow bookkeeping all update together.
  always_ff @(posedge clk or negedge hard_reset) begin
    if (!hard_reset) begin
      r_state     <= ST_IDLE;
      r_en        <= C_EN_CLEAR;
      r_lap_valid <= 1'b0;
      r_lap_value <= '0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // clear/lap has nothing to act on while idle.
          if (w_start_p) begin
            r_state <= ST_RUN;
            r_en    <= C_EN_COUNT;
          end
        end

        ST_RUN: begin
          if (w_at_wrap) begin
            // Wrap wins; any button pulse this cycle is deliberately lost.
            r_state <= ST_WRAP;
            r_en    <= C_EN_CLEAR;
            r_ovf   <= 1'b1;
          end else begin
            if (w_start_p) begin
              r_state <= ST_PAUSE;
              r_en    <= C_EN_HOLD;
            end
            if (w_clear_p) begin
              // Lap toggles: freeze on first press, release on second.
              // The old lap value stays in the register but is not shown.
              if (!r_lap_valid) begin
                r_lap_value <= sec_count;
                r_lap_valid <= 1'b1;
              end else begin
                r_lap_valid <= 1'b0;
              end
            end
          end
        end

        ST_PAUSE: begin
          if (w_clear_p) begin
            // Full clear back to idle; takes priority over resuming.
            r_state     <= ST_IDLE;
            r_en        <= C_EN_CLEAR;
            r_lap_valid <= 1'b0;
            r_lap_value <= '0;
            r_ovf       <= 1'b0;
          end else if (w_start_p) begin
            r_state <= ST_RUN;
            r_en    <= C_EN_COUNT;
          end
        end

        ST_WRAP: begin
          // Single cycle of counter clear, then resume counting.
          r_state <= ST_RUN;
          r_en    <= C_EN_COUNT;
        end

        default: begin
          r_state <= ST_IDLE;
          r_en    <= C_EN_CLEAR;
        end
      endcase
    end
  end

  assign en         = r_en;
  assign state      = r_state;
  assign lap_valid  = r_lap_valid;
  assign lap_value  = r_lap_value;
  assign ovf        = r_ovf;
  assign disp_value = r_lap_valid ? r_lap_value : sec_count;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_ctrl
//  Purpose  : Directed self-checking bench for stopwatch_ctrl
//             (DB_CYCLES=4, WRAP_VAL=20).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DB  = 4;
  localparam int CW  = 19;
  localparam int WV  = 20;

  logic          clk;
  logic          hard_reset;
  logic          btn_start;
  logic          btn_clear;
  logic [CW-1:0] sec_count;
  logic [1:0]    en;
  logic [1:0]    state;
  logic          lap_valid;
  logic [CW-1:0] lap_value;
  logic [CW-1:0] disp_value;
  logic          ovf;

  int n_checks;
  int n_errors;

  stopwatch_ctrl #(
    .DB_CYCLES (DB),
    .CNT_W     (CW),
    .WRAP_VAL  (WV)
  ) u_dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .sec_count  (sec_count),
    .en         (en),
    .state      (state),
    .lap_valid  (lap_valid),
    .lap_value  (lap_value),
    .disp_value (disp_value),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let previous button releases settle, then hold the chosen buttons high
  // from just after an edge until just after the 7th following edge, where
  // the FSM has acted on the resulting pulse.
  task automatic press(input logic s, input logic c);
    repeat (10) @(posedge clk);
    #1;
    btn_start = s;
    btn_clear = c;
    repeat (7) @(posedge clk);
    #1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic test_reset();
    hard_reset = 1'b0;
    btn_start  = 1'b0;
    btn_clear  = 1'b0;
    sec_count  = '0;
    #3;
    n_checks++;
    if ({state, en, lap_valid, ovf} !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl got state=%0d en=%0d lap_valid=%0b ovf=%0b exp all 0", state, en, lap_valid, ovf);
    end
    n_checks++;
    if (lap_value !== 19'd0) begin
      n_errors++;
      $display("FAIL reset_lap_value got %0d exp 0", lap_value);
    end
    sec_count = 19'd9;
    #1;
    n_checks++;
    if (disp_value !== 19'd9) begin
      n_errors++;
      $display("FAIL reset_disp got %0d exp 9", disp_value);
    end
    repeat (3) @(negedge clk);
    hard_reset = 1'b1;
  endtask

  task automatic test_start_latency();
    sec_count = 19'd0;
    repeat (10) @(posedge clk);
    #1;
    btn_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if ({state, en} !== 4'b0000) begin
      n_errors++;
      $display("FAIL start_edge6 got state=%0d en=%0d exp state=0 en=0", state, en);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({state, en} !== 4'b0101) begin
      n_errors++;
      $display("FAIL start_edge7 got state=%0d en=%0d exp state=1 en=1", state, en);
    end
    repeat (3) @(posedge clk);
    #1;
    btn_start = 1'b0;
  endtask

  task automatic test_glitch();
    repeat (10) @(posedge clk);
    #1;
    btn_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if ({state, en} !== 4'b0101) begin
      n_errors++;
      $display("FAIL glitch got state=%0d en=%0d exp state=1 en=1", state, en);
    end
  endtask

  task automatic test_lap();
    sec_count = 19'd12;
    press(1'b0, 1'b1);
    n_checks++;
    if ({state, lap_valid} !== 3'b011 || lap_value !== 19'd12 || disp_value !== 19'd12) begin
      n_errors++;
      $display("FAIL lap_freeze got state=%0d lap_valid=%0b lap_value=%0d disp=%0d exp 1 1 12 12",
               state, lap_valid, lap_value, disp_value);
    end
    sec_count = 19'd13;
    #1;
    n_checks++;
    if (disp_value !== 19'd12) begin
      n_errors++;
      $display("FAIL lap_hold_disp got %0d exp 12", disp_value);
    end
    sec_count = 19'd14;
    press(1'b0, 1'b1);
    n_checks++;
    if ({state, lap_valid} !== 3'b010 || lap_value !== 19'd12 || disp_value !== 19'd14) begin
      n_errors++;
      $display("FAIL lap_release got state=%0d lap_valid=%0b lap_value=%0d disp=%0d exp 1 0 12 14",
               state, lap_valid, lap_value, disp_value);
    end
    sec_count = 19'd16;
    #1;
    n_checks++;
    if (disp_value !== 19'd16) begin
      n_errors++;
      $display("FAIL lap_track_disp got %0d exp 16", disp_value);
    end
  endtask

  task automatic test_wrap();
    sec_count = 19'd19;
    repeat (10) @(posedge clk);
    #1;
    btn_start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if ({state, en, ovf} !== 5'b01010) begin
      n_errors++;
      $display("FAIL wrap_pre got state=%0d en=%0d ovf=%0b exp 1 1 0", state, en, ovf);
    end
    sec_count = 19'd20;
    @(posedge clk);
    #1;
    n_checks++;
    if ({state, en, ovf} !== 5'b11001) begin
      n_errors++;
      $display("FAIL wrap_cycle got state=%0d en=%0d ovf=%0b exp 3 0 1", state, en, ovf);
    end
    sec_count = 19'd0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({state, en, ovf} !== 5'b01011) begin
      n_errors++;
      $display("FAIL wrap_resume got state=%0d en=%0d ovf=%0b exp 1 1 1", state, en, ovf);
    end
    btn_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({state, en} !== 4'b0101) begin
      n_errors++;
      $display("FAIL wrap_pulse_dropped got state=%0d en=%0d exp 1 1", state, en);
    end
  endtask

  task automatic test_pause_sequence();
    sec_count = 19'd7;
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    n_checks++;
    if ({state, en, lap_valid, ovf} !== 6'b101011 || lap_value !== 19'd7) begin
      n_errors++;
      $display("FAIL pause1 got state=%0d en=%0d lap_valid=%0b ovf=%0b lap_value=%0d exp 2 2 1 1 7",
               state, en, lap_valid, ovf, lap_value);
    end
    press(1'b1, 1'b0);
    n_checks++;
    if ({state, en} !== 4'b0101) begin
      n_errors++;
      $display("FAIL resume got state=%0d en=%0d exp 1 1", state, en);
    end
    press(1'b1, 1'b0);
    n_checks++;
    if ({state, en} !== 4'b1010) begin
      n_errors++;
      $display("FAIL pause2 got state=%0d en=%0d exp 2 2", state, en);
    end
    press(1'b0, 1'b1);
    n_checks++;
    if ({state, en, lap_valid, ovf} !== 6'b0 || lap_value !== 19'd0 || disp_value !== 19'd7) begin
      n_errors++;
      $display("FAIL pause_clear got state=%0d en=%0d lap_valid=%0b ovf=%0b lap_value=%0d disp=%0d exp 0 0 0 0 0 7",
               state, en, lap_valid, ovf, lap_value, disp_value);
    end
  endtask

  task automatic test_both();
    press(1'b1, 1'b1);
    n_checks++;
    if ({state, en, lap_valid} !== 5'b01010) begin
      n_errors++;
      $display("FAIL both_idle got state=%0d en=%0d lap_valid=%0b exp 1 1 0", state, en, lap_valid);
    end
    sec_count = 19'd3;
    press(1'b1, 1'b1);
    n_checks++;
    if ({state, en, lap_valid} !== 5'b10101 || lap_value !== 19'd3) begin
      n_errors++;
      $display("FAIL both_run got state=%0d en=%0d lap_valid=%0b lap_value=%0d exp 2 2 1 3",
               state, en, lap_valid, lap_value);
    end
    press(1'b1, 1'b1);
    n_checks++;
    if ({state, en, lap_valid} !== 5'b00000 || lap_value !== 19'd0) begin
      n_errors++;
      $display("FAIL both_pause got state=%0d en=%0d lap_valid=%0b lap_value=%0d exp 0 0 0 0",
               state, en, lap_valid, lap_value);
    end
  endtask

  task automatic test_hard_reset();
    press(1'b1, 1'b0);
    sec_count = 19'd5;
    press(1'b0, 1'b1);
    n_checks++;
    if ({state, lap_valid} !== 3'b011 || lap_value !== 19'd5) begin
      n_errors++;
      $display("FAIL hr_setup got state=%0d lap_valid=%0b lap_value=%0d exp 1 1 5", state, lap_valid, lap_value);
    end
    repeat (10) @(posedge clk);
    #1;
    btn_start = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    hard_reset = 1'b0;
    #1;
    n_checks++;
    if ({state, en, lap_valid, ovf} !== 6'b0 || lap_value !== 19'd0 || disp_value !== 19'd5) begin
      n_errors++;
      $display("FAIL hr_async got state=%0d en=%0d lap_valid=%0b ovf=%0b lap_value=%0d disp=%0d exp 0 0 0 0 0 5",
               state, en, lap_valid, ovf, lap_value, disp_value);
    end
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
    hard_reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if ({state, en, lap_valid} !== 5'b0) begin
      n_errors++;
      $display("FAIL hr_no_spurious got state=%0d en=%0d lap_valid=%0b exp 0 0 0", state, en, lap_valid);
    end
    press(1'b1, 1'b0);
    n_checks++;
    if ({state, en} !== 4'b0101) begin
      n_errors++;
      $display("FAIL hr_recover got state=%0d en=%0d exp 1 1", state, en);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_start_latency();
    test_glitch();
    test_lap();
    test_wrap();
    test_pause_sequence();
    test_both();
    test_hard_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the seconds counter through its three mode codes: clear (00), count (01) and hold (10). It takes two raw push-buttons, start/stop and clear/lap, and synchronises, debounces and edge-detects them. It also handles lap freeze and counter wrap. Sits between the board buttons and the counter's `en` input, and supplies the display mux value.

Parameters:
DB_CYCLES, 20, consecutive stable cycles required before a debounced level changes (>=2)
CNT_W, 19, width of counter value / lap register
WRAP_VAL, 500000, counter terminal value; must fit in CNT_W bits

Ports:
clk  in  1  system clock
hard_reset  in  1  asynchronous active-low reset
btn_start  in  1  raw start/stop button, active-high, asynchronous to clk
btn_clear  in  1  raw clear/lap button, active-high, asynchronous to clk
sec_count  in  CNT_W  live counter value fed back from the counter
en  out  2  registered mode code to counter: 00 clear, 01 count, 10 hold
state  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 WRAP
lap_valid  out  1  lap value frozen
lap_value  out  CNT_W  captured counter value
disp_value  out  CNT_W  combinational: lap_valid ? lap_value : sec_count
ovf  out  1  sticky: counter wrapped at least once since the last IDLE

Behaviour:
- Reset values (async, on hard_reset low): state=IDLE, en=00, lap_valid=0, lap_value=0, ovf=0. All sync flops, debounce counters and debounced levels are 0.
- Button path (each button independent):
  - Two-flop synchroniser, followed by a debounce counter.
  - The counter increments while the sync output differs from the debounced level and clears to 0 when they are equal.
  - When the count is DB_CYCLES-1 and the levels still differ, the debounced level toggles on that edge and the counter clears.
  - Rising edge of the debounced level gives a one-cycle pulse (start_p / clear_p). Falling edges produce no pulse.
  - Latency: raw input first sampled high at edge 1 and held stable → en/state update at edge DB_CYCLES+3.
  - Glitches shorter than DB_CYCLES cycles produce no pulse.
  - A button held across reset release produces exactly one pulse, once debounced.
- FSM transitions (state and en registered together; en = 00 in IDLE/WRAP, 01 in RUN, 10 in PAUSE):
  - IDLE: start_p → RUN. clear_p alone → stay IDLE, no effect.
  - RUN: start_p → PAUSE.
  - RUN: clear_p with lap_valid=0 → lap_value <= sec_count and lap_valid <= 1. With lap_valid=1 → lap_valid <= 0; lap_value is retained but not displayed.
  - RUN: sec_count == WRAP_VAL → WRAP (takes priority over start_p/clear_p that cycle; those pulses are dropped). ovf <= 1.
  - WRAP: unconditional → RUN after exactly one cycle, so en=00 for exactly one cycle. Pulses arriving in WRAP are dropped.
  - PAUSE: start_p → RUN.
  - PAUSE: clear_p → IDLE, which clears lap_valid, lap_value and ovf. clear_p has priority over start_p in PAUSE.
  - Simultaneous start_p and clear_p: in IDLE → RUN. In RUN → PAUSE and the lap toggle both occur.
- disp_value follows lap_valid with zero latency. No arithmetic is performed on sec_count; comparison is an exact equality on CNT_W bits.
- Hard reset mid-operation returns immediately to reset values, regardless of state or pending debounce.

Test Plan:
(Bench with DB_CYCLES=4, WRAP_VAL=20.)
- Reset then btn_start high held 10 cycles → en goes 00→01 at edge 7 after first sampling, state=1. A 3-cycle btn_start glitch → no change.
- RUN with sec_count=12, press clear → lap_valid=1, lap_value=12, disp_value=12 while sec_count advances. Press clear again → lap_valid=0, disp_value tracks sec_count.
- RUN, drive sec_count=20 → state=3 and en=00 for one cycle, then state=1 and en=01, ovf=1. A start pulse coinciding with that cycle is ignored.
- RUN → start (PAUSE, en=10) → start (RUN, en=01) → start (PAUSE) → clear → state=0, en=00, lap_valid=0, lap_value=0, ovf=0.
- PAUSE with start and clear pulsing the same cycle → IDLE. IDLE with both pulsing the same cycle → RUN.
- Assert hard_reset low during RUN with lap_valid=1 and debounce mid-count → all outputs at reset values immediately. After release, no spurious pulse if the buttons are low.
